riscv_nn_imem_line_responder: RTL and testbench
===============================================

// Module: riscv_nn_imem_line_responder
// PURPOSE
//  Responder end of the 128-bit instruction-line fetch protocol used by the NN L0 buffer.
//  - Accepts one line request (req/gnt) at a time.
//  - Fetches the line as NB_WORDS in-order 32-bit beats from a word-wide pipelined backing memory.
//  - Assembles the beats and returns the whole line with a single-cycle rvalid.
//  - Sits between the core-side L0 buffer and the instruction TCDM/ROM.
// PARAMETERS
//  LINE_WIDTH   128  line width in bits; multiple of 32, power of 2; NB_WORDS = LINE_WIDTH/32
//  OFFS_BITS    derived  $clog2(LINE_WIDTH/8); byte-offset bits inside a line (4 for 128)
// PORTS
//  clk              in   1         clock
//  rst_n            in   1         reset, asynchronous, active-low
//  instr_req_i      in   1         line request from L0 buffer
//  instr_addr_i     in   32        request byte address; bits [OFFS_BITS-1:0] ignored
//  instr_gnt_o      out  1         request accepted this cycle
//  instr_rvalid_o   out  1         instr_rdata_o valid this cycle (1-cycle pulse)
//  instr_rdata_o    out  LINE_WIDTH  line data, word k at bits [32k+31:32k]
//  flush_i          in   1         invalidate last-line tag (only used with LAST_LINE_CACHE_EN)
//  mem_req_o        out  1         backing-memory word request
//  mem_addr_o       out  32        word address = {line_q[31:OFFS_BITS], issue_cnt, 2'b00}
//  mem_gnt_i        in   1         backing-memory grant
//  mem_rvalid_i     in   1         backing-memory read data valid, in request order, >=1 cycle after gnt
//  mem_rdata_i      in   32        backing-memory read data
//  busy_o           out  1         CS != IDLE
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; instr_rdata_o = 0; line_q = 0.
//  - Counters = 0; CS = IDLE; tag_valid = 0.
//  FSM states: IDLE, FETCH, RESP.
//  IDLE:
//  - instr_gnt_o = instr_req_i (combinational).
//  - On grant: line_q <= {instr_addr_i[31:OFFS_BITS], 0}; issue_cnt = recv_cnt = 0; NS = FETCH.
//  FETCH, issue side:
//  - mem_req_o = (issue_cnt < NB_WORDS).
//  - On mem_gnt_i with mem_req_o: issue_cnt++.
//  - issue_cnt is OFFS_BITS-2 bits plus a done bit, so it saturates at NB_WORDS and never wraps.
//  FETCH, receive side:
//  - On mem_rvalid_i: word[recv_cnt] <= mem_rdata_i; recv_cnt++.
//  - Issue and receive overlap, so multiple beats may be outstanding.
//  - When mem_rvalid_i && recv_cnt == NB_WORDS-1: NS = RESP.
//  - instr_gnt_o = 0 throughout FETCH.
//  RESP:
//  - instr_rvalid_o = 1 for exactly one cycle.
//  - instr_rdata_o (registered) holds the assembled line and stays stable until the next line completes.
//  - Same-cycle new request: instr_gnt_o = instr_req_i; on grant, capture the new line_q and go to FETCH.
//    This gives back-to-back lines with no idle bubble.
//  - Otherwise NS = IDLE.
//  Latency, zero-wait memory (gnt every cycle, rvalid 1 cycle after gnt):
//  - Grant in cycle t; beats issued t+1..t+NB_WORDS; instr_rvalid_o in t+NB_WORDS+2 (t+6 for 128 bits).
//  Protocol rules:
//  - Every granted request gets exactly one rvalid; there is no abort.
//  - The requester must accept rvalid even if it has branched away.
//  - mem_rvalid_i outside FETCH is ignored.
//  - mem_addr_o is held stable while mem_req_o && !mem_gnt_i.
//  Reset mid-fetch:
//  - Asynchronous return to IDLE; partial line discarded; no rvalid.
//  - The backing memory shares rst_n, so no stale responses arrive.
// CONFIGURATION
//  Macro: RISCV_NN_LAST_LINE_CACHE_EN
//  - Defined: keeps tag_q (line index) and tag_valid.
//    - tag_valid is set on each FETCH completion (tag_q <= line_q).
//    - A grant in IDLE or RESP with tag_valid && index match goes straight to RESP the next cycle.
//    - That hit path uses no mem_req_o; rvalid latency is 1 cycle; rdata is the held line.
//    - flush_i clears tag_valid at the next edge.
//    - If flush_i coincides with a matching grant, the request is treated as a miss.
//  - Undefined: no tag logic; flush_i ignored; every request performs a full FETCH.
// TESTING
//  1 Zero-wait mem, req addr 0x1000, mem words 0xA0,0xA1,0xA2,0xA3
//    -> mem_addr 0x1000/04/08/0C; rvalid at t+6; rdata={A3,A2,A1,A0}.
//  2 Unaligned req 0x100A
//    -> fetch addresses 0x1000..0x100C; identical line returned.
//  3 Req 0x2000, then new req 0x3000 held high during RESP
//    -> gnt in RESP cycle; second rvalid at RESP+6; no idle cycle.
//  4 Random mem_gnt stalls, rvalid delayed 1-3 cycles, 2 beats outstanding
//    -> words assembled in order; mem_addr stable while stalled; one rvalid per grant.
//  5 Assert rst_n low after 2 beats of line 0x4000
//    -> all outputs 0 next cycle; no rvalid; a fresh req 0x4000 completes normally.
//  6 RISCV_NN_LAST_LINE_CACHE_EN: req 0x5000 twice
//    -> second rvalid at t+1 with no mem_req_o; flush_i then req 0x5000 -> full fetch (t+6).

Source files
------------

// File: rtl/riscv_nn_imem_line_responder_if.sv
// Word/line fetch channel (req/gnt address phase, rvalid data phase), shared by the
// core-side line port and the backing-memory word port; the master drives req/addr.
interface riscv_nn_imem_line_responder_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  req;
    logic [31:0]           addr;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, addr, input  gnt, rvalid, rdata);
    modport slave  (input  req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/riscv_nn_imem_line_responder.sv
// Fetches one instruction line as in-order word beats and returns it with a 1-cycle rvalid; t+NB_WORDS+2
// zero-wait latency, one line in flight, mem stalls via mem.gnt. RISCV_NN_LAST_LINE_CACHE_EN adds a last-line hit path.
module riscv_nn_imem_line_responder #(
    parameter int LINE_WIDTH = 128
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    riscv_nn_imem_line_responder_if.slave         instr,
    riscv_nn_imem_line_responder_if.master        mem,
    input  logic                                  flush_i,
    output logic                                  busy_o
);

    localparam int NB_WORDS  = LINE_WIDTH / 32;
    localparam int OFFS_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W     = OFFS_BITS - 2;
    localparam int IDX_W     = 32 - OFFS_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                     cs, ns;
    logic [IDX_W-1:0]           line_q;
    logic [CNT_W:0]             issue_cnt_q;
    logic [CNT_W-1:0]           recv_cnt_q;
    logic [NB_WORDS-1:0][31:0]  word_q;
    logic [NB_WORDS-1:0][31:0]  line_asm;
    logic [LINE_WIDTH-1:0]      rdata_q;

    logic accept;
    logic last_beat;
    logic fetch_beat;
    logic hit;

    logic unused_addr;
    assign unused_addr = ^instr.addr[OFFS_BITS-1:0];

`ifdef RISCV_NN_LAST_LINE_CACHE_EN
    logic [IDX_W-1:0] tag_q;
    logic             tag_valid_q;

    // A flush in the same cycle as a matching grant forces a miss.
    assign hit = tag_valid_q && !flush_i && (instr.addr[31:OFFS_BITS] == tag_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            if (flush_i)
                tag_valid_q <= 1'b0;
            else if (last_beat)
                tag_valid_q <= 1'b1;
            if (last_beat)
                tag_q <= line_q;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign hit          = 1'b0;
`endif

    always_comb begin
        ns        = cs;
        instr.gnt = 1'b0;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (cs)
            IDLE: begin
                instr.gnt = instr.req;
                if (instr.req) begin
                    accept = 1'b1;
                    ns     = hit ? RESP : FETCH;
                end
            end
            FETCH: begin
                if (mem.rvalid && (recv_cnt_q == CNT_W'(NB_WORDS - 1))) begin
                    last_beat = 1'b1;
                    ns        = RESP;
                end
            end
            RESP: begin
                // Back-to-back lines: a waiting request is granted in the response cycle.
                instr.gnt = instr.req;
                if (instr.req) begin
                    accept = 1'b1;
                    ns     = hit ? RESP : FETCH;
                end else begin
                    ns = IDLE;
                end
            end
            default: ns = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cs <= IDLE;
        else
            cs <= ns;
    end

    // Top bit of issue_cnt_q is the done flag, so the counter parks at NB_WORDS.
    assign mem.req    = (cs == FETCH) && !issue_cnt_q[CNT_W];
    assign mem.addr   = {line_q, issue_cnt_q[CNT_W-1:0], 2'b00};
    assign fetch_beat = (cs == FETCH) && mem.rvalid;

    always_comb begin
        line_asm             = word_q;
        line_asm[recv_cnt_q] = mem.rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            word_q      <= '0;
        end else if (accept) begin
            line_q      <= instr.addr[31:OFFS_BITS];
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else if (cs == FETCH) begin
            if (mem.req && mem.gnt)
                issue_cnt_q <= issue_cnt_q + (CNT_W + 1)'(1);
            if (fetch_beat) begin
                word_q[recv_cnt_q] <= mem.rdata;
                recv_cnt_q         <= recv_cnt_q + CNT_W'(1);
            end
        end
    end

    // Separate output register keeps the returned line stable while the next one assembles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata_q <= '0;
        else if (last_beat)
            rdata_q <= line_asm;
    end

    assign instr.rvalid = (cs == RESP);
    assign instr.rdata  = rdata_q;
    assign busy_o       = (cs != IDLE);

endmodule

// File: tb/tb_riscv_nn_imem_line_responder.sv
// Directed bench for the line responder with a pipelined word-memory model (zero-wait or stalling).
module tb_riscv_nn_imem_line_responder;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mode = 0;
    int   beats = 0;
    int   rv_count = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       mq[$];
    logic [31:0] issued_q[$];
    logic        stall_pend = 1'b0;
    logic [31:0] stall_addr = '0;

    riscv_nn_imem_line_responder_if #(.DATA_WIDTH(128)) instr_if ();
    riscv_nn_imem_line_responder_if #(.DATA_WIDTH(32))  mem_if ();

    riscv_nn_imem_line_responder #(.LINE_WIDTH(128)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .instr   (instr_if),
        .mem     (mem_if),
        .flush_i (flush),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (instr_if.rvalid === 1'b1) rv_count <= rv_count + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h0000100)
            return 32'hA0 + {30'b0, a[3:2]};
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: drives after the rising edge, logs address handshakes at the falling edge.
    initial begin
        pend_t p;
        mem_if.gnt    = 1'b0;
        mem_if.rvalid = 1'b0;
        mem_if.rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_if.rvalid = 1'b0;
            mem_if.rdata  = '0;
            if (!rst_n) begin
                mq.delete();
                mem_if.gnt = 1'b0;
            end else begin
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    p             = mq.pop_front();
                    mem_if.rvalid = 1'b1;
                    mem_if.rdata  = mem_word(p.addr);
                    beats++;
                end
                if (mode == 0)
                    mem_if.gnt = 1'b1;
                else
                    mem_if.gnt = (mq.size() < 2) && ($urandom_range(0, 2) != 0);
            end
        end
    end

    initial begin
        pend_t p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_pend && mem_if.req)
                    chk("addr_hold", {96'b0, mem_if.addr}, {96'b0, stall_addr});
                if (mem_if.req && mem_if.gnt) begin
                    p.addr = mem_if.addr;
                    p.due  = cyc + ((mode == 0) ? 1 : int'($urandom_range(1, 3)));
                    mq.push_back(p);
                    issued_q.push_back(mem_if.addr);
                end
                stall_pend = mem_if.req && !mem_if.gnt;
                stall_addr = mem_if.addr;
            end else begin
                stall_pend = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic fl, output int t);
        @(negedge clk);
        instr_if.req  = 1'b1;
        instr_if.addr = a;
        flush         = fl;
        #1;
        chk("req_gnt", {127'b0, instr_if.gnt}, 128'd1);
        t = cyc;
        @(posedge clk);
        #1;
        instr_if.req = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic wait_rv(input int budget, output int at, output logic [127:0] dat);
        at  = -1;
        dat = 'x;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (instr_if.rvalid === 1'b1) begin
                at  = cyc;
                dat = instr_if.rdata;
                break;
            end
        end
    endtask

    task automatic chk_addrs(input string tag, input logic [31:0] base);
        chk({tag, "_n"}, 128'(issued_q.size()), 128'd4);
        for (int k = 0; k < 4; k++)
            chk(tag, {96'b0, issued_q[k]}, {96'b0, base + 32'(4 * k)});
    endtask

    initial begin
        int t, t2, at, rv0;
        logic [127:0] dat;
        rst_n         = 1'b0;
        flush         = 1'b0;
        instr_if.req  = 1'b0;
        instr_if.addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_rvalid", {127'b0, instr_if.rvalid}, 128'd0);
        chk("rst_rdata",  instr_if.rdata, 128'd0);
        chk("rst_gnt",    {127'b0, instr_if.gnt}, 128'd0);
        chk("rst_memreq", {127'b0, mem_if.req}, 128'd0);
        chk("rst_memaddr", {96'b0, mem_if.addr}, 128'd0);
        chk("rst_busy",   {127'b0, busy}, 128'd0);
        rst_n = 1'b1;

        // 1: zero-wait aligned line
        issued_q.delete();
        send(32'h1000, 1'b0, t);
        chk("t1_busy", {127'b0, busy}, 128'd1);
        wait_rv(20, at, dat);
        chk("t1_lat",  128'(at - t), 128'd6);
        chk("t1_data", dat, 128'h000000A3_000000A2_000000A1_000000A0);
        chk_addrs("t1_addr", 32'h1000);
        @(negedge clk);
        chk("t1_pulse", {127'b0, instr_if.rvalid}, 128'd0);
        chk("t1_idle",  {127'b0, busy}, 128'd0);
        chk("t1_hold",  instr_if.rdata, 128'h000000A3_000000A2_000000A1_000000A0);

        // 2: unaligned address, flush alongside the grant (miss even with the last-line cache)
        issued_q.delete();
        send(32'h100A, 1'b1, t);
        wait_rv(20, at, dat);
        chk("t2_lat",  128'(at - t), 128'd6);
        chk("t2_data", dat, 128'h000000A3_000000A2_000000A1_000000A0);
        chk_addrs("t2_addr", 32'h1000);

        // 3: back-to-back, second request held high through FETCH and RESP
        @(negedge clk);
        instr_if.req  = 1'b1;
        instr_if.addr = 32'h2000;
        #1;
        chk("t3_gnt0", {127'b0, instr_if.gnt}, 128'd1);
        t = cyc;
        @(posedge clk);
        #1;
        instr_if.addr = 32'h3000;
        #1;
        chk("t3_gnt_fetch", {127'b0, instr_if.gnt}, 128'd0);
        wait_rv(20, at, dat);
        chk("t3_lat0",  128'(at - t), 128'd6);
        chk("t3_data0", dat, 128'h5A5A200C_5A5A2008_5A5A2004_5A5A2000);
        chk("t3_gnt_resp", {127'b0, instr_if.gnt}, 128'd1);
        t2 = at;
        @(posedge clk);
        #1;
        instr_if.req = 1'b0;
        chk("t3_nobubble", {127'b0, busy}, 128'd1);
        wait_rv(20, at, dat);
        chk("t3_lat1",  128'(at - t2), 128'd6);
        chk("t3_data1", dat, 128'h5A5A300C_5A5A3008_5A5A3004_5A5A3000);

        // 4: stalling memory, delayed rvalid, up to two beats outstanding
        @(negedge clk);
        mode = 1;
        rv0  = rv_count;
        issued_q.delete();
        send(32'h6004, 1'b0, t);
        wait_rv(300, at, dat);
        chk("t4_done0", {127'b0, at > 0}, 128'd1);
        chk("t4_data0", dat, 128'h5A5A600C_5A5A6008_5A5A6004_5A5A6000);
        chk_addrs("t4_addr0", 32'h6000);
        issued_q.delete();
        send(32'h6010, 1'b0, t);
        wait_rv(300, at, dat);
        chk("t4_data1", dat, 128'h5A5A601C_5A5A6018_5A5A6014_5A5A6010);
        chk_addrs("t4_addr1", 32'h6010);
        repeat (6) @(negedge clk);
        #1;
        chk("t4_rvcount", 128'(rv_count - rv0), 128'd2);
        mode = 0;

        // 5: reset after two beats of line 0x4000
        beats = 0;
        send(32'h4000, 1'b0, t);
        for (int i = 0; i < 20 && beats < 2; i++) @(negedge clk);
        @(negedge clk);
        rv0   = rv_count;
        rst_n = 1'b0;
        #1;
        chk("t5_busy",    {127'b0, busy}, 128'd0);
        chk("t5_memreq",  {127'b0, mem_if.req}, 128'd0);
        chk("t5_memaddr", {96'b0, mem_if.addr}, 128'd0);
        chk("t5_rvalid",  {127'b0, instr_if.rvalid}, 128'd0);
        chk("t5_rdata",   instr_if.rdata, 128'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_norv", 128'(rv_count - rv0), 128'd0);
        rst_n = 1'b1;
        issued_q.delete();
        send(32'h4000, 1'b0, t);
        wait_rv(20, at, dat);
        chk("t5_lat",  128'(at - t), 128'd6);
        chk("t5_data", dat, 128'h5A5A400C_5A5A4008_5A5A4004_5A5A4000);
        chk_addrs("t5_addr", 32'h4000);

        // 6: repeated line 0x5000
        issued_q.delete();
        send(32'h5000, 1'b0, t);
        wait_rv(20, at, dat);
        chk("t6_lat0",  128'(at - t), 128'd6);
        chk("t6_data0", dat, 128'h5A5A500C_5A5A5008_5A5A5004_5A5A5000);
        send(32'h5008, 1'b0, t);
        wait_rv(20, at, dat);
`ifdef RISCV_NN_LAST_LINE_CACHE_EN
        chk("t6_hit_lat", 128'(at - t), 128'd1);
        chk("t6_hit_nomem", 128'(issued_q.size()), 128'd4);
`else
        chk("t6_lat1", 128'(at - t), 128'd6);
        chk("t6_mem1", 128'(issued_q.size()), 128'd8);
`endif
        chk("t6_data1", dat, 128'h5A5A500C_5A5A5008_5A5A5004_5A5A5000);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        issued_q.delete();
        send(32'h5000, 1'b0, t);
        wait_rv(20, at, dat);
        chk("t6_flush_lat", 128'(at - t), 128'd6);
        chk("t6_flush_data", dat, 128'h5A5A500C_5A5A5008_5A5A5004_5A5A5000);
        chk_addrs("t6_flush_addr", 32'h5000);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
